// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the serial carry-lookahead adder:
//   CLA_SLICE_W : bit width of one datapath slice (one nibble)
//   state_e     : controller states IDLE / CALC / DONE
//   cnt_width() : width of the slice counter, never less than 1 bit
// ---------------------------------------------------------------------------
package arith_pkg;

  localparam int CLA_SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to count 0..n-1; a single slice still gets a 1-bit counter.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/carry_lookahead_adder_4b.sv
// ---------------------------------------------------------------------------
// carry_lookahead_adder_4b
// Purely combinational 4-bit carry-lookahead adder.
// Ports:
//   a, b  in  [3:0]  addends
//   cin   in  1      carry into bit 0
//   sum   out [3:0]  a + b + cin (low 4 bits)
//   cout  out 1      carry out of bit 3
// ---------------------------------------------------------------------------
module carry_lookahead_adder_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is expanded directly from generate/propagate terms and cin.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/serial_cla_adder.sv
// ---------------------------------------------------------------------------
// serial_cla_adder
// Multi-cycle WIDTH-bit adder: operands are processed one nibble per cycle,
// LSB first, through a single 4-bit CLA, with the inter-nibble carry held in
// a register. Valid/ready handshakes on both the operand and result sides.
//
// Optional build macro: SERIAL_CLA_SUBTRACT_EN adds the iSub port; when
// iSub=1 the block computes A - B - borrow (iCarryIn is the borrow-in and
// oCarry=1 means no borrow out).
//
// Ports:
//   iClk      in   1      clock, rising edge
//   iRst      in   1      synchronous active-high reset
//   iValid    in   1      operands valid
//   oReady    out  1      block accepts operands (IDLE)
//   iA, iB    in   WIDTH  operands
//   iCarryIn  in   1      carry into bit 0
//   iSub      in   1      subtract select (SERIAL_CLA_SUBTRACT_EN only)
//   oValid    out  1      result valid (DONE)
//   iReady    in   1      downstream accepts result
//   oSum      out  WIDTH  sum
//   oCarry    out  1      carry out of bit WIDTH-1
//   oOverflow out  1      signed two's-complement overflow
// ---------------------------------------------------------------------------
module serial_cla_adder #(
  parameter int WIDTH = 16
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iCarryIn,
`ifdef SERIAL_CLA_SUBTRACT_EN
  input  logic             iSub,
`endif
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oSum,
  output logic             oCarry,
  output logic             oOverflow
);

  import arith_pkg::*;

  localparam int NSLICE = WIDTH / CLA_SLICE_W;
  localparam int CNT_W  = cnt_width(NSLICE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   b_eff;
  logic               cin_eff;
  logic [CNT_W+1:0]   bit_base;
  logic [3:0]         cla_a;
  logic [3:0]         cla_b;
  logic [3:0]         cla_sum;
  logic               cla_cout;

  // Effective B operand and carry-in as they will be stored at acceptance.
  always_comb begin
`ifdef SERIAL_CLA_SUBTRACT_EN
    if (iSub) begin
      b_eff   = ~iB;
      cin_eff = ~iCarryIn;
    end else begin
      b_eff   = iB;
      cin_eff = iCarryIn;
    end
`else
    b_eff   = iB;
    cin_eff = iCarryIn;
`endif
  end

  // Bit offset of the current nibble is counter * 4.
  assign bit_base = {cnt_q, 2'b00};
  assign cla_a    = a_q[bit_base +: CLA_SLICE_W];
  assign cla_b    = b_q[bit_base +: CLA_SLICE_W];

  carry_lookahead_adder_4b u_cla (
    .a    (cla_a),
    .b    (cla_b),
    .cin  (carry_q),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  // Next-state and datapath update for the IDLE/CALC/DONE controller.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    valid_d = valid_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        // oReady is 1 in IDLE, so iValid alone completes the handshake.
        if (iValid) begin
          a_d     = iA;
          b_d     = b_eff;
          carry_d = cin_eff;
          cnt_d   = '0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        res_d[bit_base +: CLA_SLICE_W] = cla_sum;
        carry_d = cla_cout;
        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          valid_d = 1'b1;
          sum_d   = res_d;
          cout_d  = cla_cout;
          // Top sum bit comes from bit 3 of the final slice.
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (cla_sum[3] != a_q[WIDTH-1]);
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        if (iReady) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign oReady    = (state_q == IDLE);
  assign oValid    = valid_q;
  assign oSum      = sum_q;
  assign oCarry    = cout_q;
  assign oOverflow = ovf_q;

endmodule
